// File: rtl/west_skew_feeder_if.sv
// West-edge feeder bundle: tile control, column-vector valid/ready input, skewed per-row outputs.
// master drives tile control and vectors; slave is the feeder that returns ready, skewed data and status.
interface west_skew_feeder_if #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 4,
    parameter int LEN_W = 16
);
    logic                  start_i;
    logic [LEN_W-1:0]      len_i;
    logic                  abort_i;
    logic                  in_valid_i;
    logic [ROWS*WIDTH-1:0] in_data_i;
    logic                  in_ready_o;
    logic [ROWS*WIDTH-1:0] west_o;
    logic [ROWS-1:0]       west_valid_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output start_i, len_i, abort_i, in_valid_i, in_data_i,
        input  in_ready_o, west_o, west_valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, len_i, abort_i, in_valid_i, in_data_i,
        output in_ready_o, west_o, west_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/west_skew_feeder.sv
// Skews column vectors onto the systolic array west edge; row r lags by r cycles and emits a done pulse per tile.
// Latency: row r shows a vector r+1 cycles after its handshake; ready is high only while streaming, with no stall input.
module west_skew_feeder #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 4,
    parameter int LEN_W = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    west_skew_feeder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);
    localparam logic [LEN_W-1:0] DRAIN_INIT = LEN_W'(ROWS - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] drain_q, drain_d;
    logic             done_q, done_d;
    logic             in_rdy;
    logic             in_hs;

    logic [ROWS-1:0][WIDTH-1:0] west_dat;
    logic [ROWS-1:0]            west_vld;

    // Ready depends on state only, except that abort suppresses it in the same cycle.
    assign in_rdy = (state_q == STREAM) && !bus.abort_i;
    assign in_hs  = bus.in_valid_i && in_rdy;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i && (bus.len_i != '0)) begin
                    state_d = STREAM;
                    rem_d   = bus.len_i;
                end
            end
            STREAM: begin
                if (in_hs) begin
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE) begin
                        // A single row has no skew to drain, so the tile ends with its last handshake.
                        if (ROWS == 1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                            drain_d = DRAIN_INIT;
                        end
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q - ONE;
                if (drain_q == ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.abort_i) begin
            state_d = IDLE;
            rem_d   = '0;
            drain_d = '0;
            done_d  = 1'b0;
        end
    end

    // Row r owns r+1 stages; every stage shifts every cycle so a stall becomes a zero bubble, never a hold.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [r:0][WIDTH-1:0] dat_q;
        logic [r:0]            vld_q;

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                dat_q <= '0;
                vld_q <= '0;
            end else if (bus.abort_i) begin
                dat_q <= '0;
                vld_q <= '0;
            end else begin
                dat_q[0] <= in_hs ? bus.in_data_i[r*WIDTH +: WIDTH] : '0;
                vld_q[0] <= in_hs;
                for (int s = 1; s <= r; s++) begin
                    dat_q[s] <= dat_q[s-1];
                    vld_q[s] <= vld_q[s-1];
                end
            end
        end

        assign west_dat[r] = dat_q[r];
        assign west_vld[r] = vld_q[r];
    end

    assign bus.in_ready_o   = in_rdy;
    assign bus.west_o       = west_dat;
    assign bus.west_valid_o = west_vld;
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.done_o       = done_q;
endmodule

// File: tb/tb_west_skew_feeder.sv
// Bench for west_skew_feeder: directed scenarios plus random tiles against a history-based reference model.
module tb_west_skew_feeder;
    localparam int W    = 8;
    localparam int R    = 4;
    localparam int LW   = 16;
    localparam int MAXC = 2048;

    logic clk;
    logic rstn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    west_skew_feeder_if #(.WIDTH(W), .ROWS(R), .LEN_W(LW)) b4 ();
    west_skew_feeder_if #(.WIDTH(W), .ROWS(1), .LEN_W(LW)) b1 ();

    west_skew_feeder #(.WIDTH(W), .ROWS(R), .LEN_W(LW)) dut4 (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (b4)
    );

    west_skew_feeder #(.WIDTH(W), .ROWS(1), .LEN_W(LW)) dut1 (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (b1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what was accepted at each edge, plus the tile's progress.
    int             cyc = 0;
    bit             hs_v [MAXC];
    logic [R*W-1:0] hs_d [MAXC];
    bit             m_active = 0;
    int             m_len = 0;
    int             m_acc = 0;
    int             m_done_e = -1;
    int             obs_n_done = 0;
    int             obs_done_at = -1;

    function automatic logic [R*W-1:0] mkvec(int base);
        logic [R*W-1:0] v;
        for (int r = 0; r < R; r++) v[r*W +: W] = W'(base + r);
        return v;
    endfunction

    task automatic model_clear();
        m_active = 0;
        m_len    = 0;
        m_acc    = 0;
        m_done_e = -1;
        for (int i = 0; i <= cyc; i++) hs_v[i] = 0;
    endtask

    task automatic idle_in();
        b4.start_i    = 1'b0;
        b4.len_i      = '0;
        b4.abort_i    = 1'b0;
        b4.in_valid_i = 1'b0;
        b4.in_data_i  = '0;
    endtask

    // One clock: check ready before the edge, advance the model at the edge, check all outputs after it.
    task automatic tick();
        bit             exp_rdy, hs, exp_v;
        logic [W-1:0]   exp_w;
        int             k;
        #4;
        exp_rdy = m_active && (m_acc < m_len) && !b4.abort_i && rstn;
        n_vec++;
        if (b4.in_ready_o !== exp_rdy) begin
            n_err++;
            $display("FAIL in_ready edge=%0d got=%b exp=%b", cyc + 1, b4.in_ready_o, exp_rdy);
        end
        hs = exp_rdy && b4.in_valid_i;
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget edge=%0d exceeded limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        hs_v[cyc] = hs;
        hs_d[cyc] = b4.in_data_i;
        if (!rstn || b4.abort_i) begin
            model_clear();
        end else begin
            if (!m_active) begin
                if (b4.start_i && (b4.len_i != '0)) begin
                    m_active = 1;
                    m_len    = int'(b4.len_i);
                    m_acc    = 0;
                    m_done_e = -1;
                end
            end else if (hs) begin
                m_acc++;
                if (m_acc == m_len) m_done_e = cyc + R - 1;
            end
            if (m_active && (cyc == m_done_e)) m_active = 0;
        end
        #1;
        n_vec++;
        if (b4.busy_o !== m_active) begin
            n_err++;
            $display("FAIL busy edge=%0d got=%b exp=%b", cyc, b4.busy_o, m_active);
        end
        n_vec++;
        if (b4.done_o !== (cyc == m_done_e)) begin
            n_err++;
            $display("FAIL done edge=%0d got=%b exp=%b", cyc, b4.done_o, (cyc == m_done_e));
        end
        for (int r = 0; r < R; r++) begin
            k     = cyc - r;
            exp_v = 0;
            exp_w = '0;
            if (k >= 0) begin
                if (hs_v[k]) begin
                    exp_v = 1;
                    exp_w = hs_d[k][r*W +: W];
                end
            end
            n_vec++;
            if ((b4.west_valid_o[r] !== exp_v) || (b4.west_o[r*W +: W] !== exp_w)) begin
                n_err++;
                $display("FAIL west_row%0d edge=%0d got=%b/%h exp=%b/%h", r, cyc,
                         b4.west_valid_o[r], b4.west_o[r*W +: W], exp_v, exp_w);
            end
        end
        if (b4.done_o === 1'b1) begin
            obs_n_done++;
            obs_done_at = cyc;
        end
    endtask

    task automatic run_idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_done(string name, int exp_n, int exp_at);
        n_vec++;
        if ((obs_n_done !== exp_n) || ((exp_n == 1) && (obs_done_at !== exp_at))) begin
            n_err++;
            $display("FAIL %s done_pulses got=%0d@%0d exp=%0d@%0d", name, obs_n_done, obs_done_at, exp_n, exp_at);
        end
        obs_n_done  = 0;
        obs_done_at = -1;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        idle_in();
        b1.start_i = 1'b0; b1.len_i = '0; b1.abort_i = 1'b0;
        b1.in_valid_i = 1'b0; b1.in_data_i = '0;
        #1 rstn = 1'b0;
        #2;
        n_vec++; if (b4.in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", b4.in_ready_o); end
        n_vec++; if (b4.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", b4.busy_o); end
        n_vec++; if (b4.done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", b4.done_o); end
        n_vec++; if (b4.west_o !== '0) begin n_err++; $display("FAIL reset_west got=%h exp=0", b4.west_o); end
        n_vec++; if (b4.west_valid_o !== '0) begin n_err++; $display("FAIL reset_wvld got=%b exp=0", b4.west_valid_o); end
        n_vec++; if ({b1.in_ready_o, b1.busy_o, b1.done_o, b1.west_valid_o} !== 4'b0) begin
            n_err++; $display("FAIL reset_rows1_ctl got=%b exp=0000", {b1.in_ready_o, b1.busy_o, b1.done_o, b1.west_valid_o});
        end
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_basic_skew();
        int s;
        idle_in();
        b4.start_i = 1'b1; b4.len_i = 16'd3;
        tick(); s = cyc;
        idle_in();
        for (int i = 0; i < 3; i++) begin
            b4.in_valid_i = 1'b1; b4.in_data_i = mkvec(1 + 4 * i);
            tick();
        end
        idle_in();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cyc == s + 6) begin
                n_vec++;
                if (b4.west_o[3*W +: W] !== 8'd12) begin
                    n_err++; $display("FAIL basic_last_row3 got=%0d exp=12", b4.west_o[3*W +: W]);
                end
            end
        end
        check_done("basic", 1, s + 6);
    endtask

    task automatic test_stall();
        int s;
        idle_in();
        b4.start_i = 1'b1; b4.len_i = 16'd3;
        tick(); s = cyc;
        idle_in();
        b4.in_valid_i = 1'b1; b4.in_data_i = mkvec(1); tick();
        b4.in_valid_i = 1'b0; b4.in_data_i = mkvec(100); tick(); tick();
        b4.in_valid_i = 1'b1; b4.in_data_i = mkvec(5); tick();
        b4.in_data_i = mkvec(9); tick();
        idle_in();
        run_idle(8);
        check_done("stall", 1, s + 8);
    endtask

    task automatic test_zero_len_and_busy_start();
        int s;
        idle_in();
        b4.start_i = 1'b1; b4.len_i = '0;
        tick();
        idle_in();
        run_idle(4);
        check_done("zero_len", 0, -1);
        b4.start_i = 1'b1; b4.len_i = 16'd3;
        tick(); s = cyc;
        idle_in();
        b4.in_valid_i = 1'b1; b4.in_data_i = mkvec(20); tick();
        b4.start_i = 1'b1; b4.len_i = 16'd9; b4.in_data_i = mkvec(24); tick();
        b4.start_i = 1'b0; b4.len_i = '0; b4.in_data_i = mkvec(28); tick();
        idle_in();
        run_idle(8);
        check_done("busy_start", 1, s + 6);
    endtask

    task automatic test_abort();
        int s;
        idle_in();
        b4.start_i = 1'b1; b4.len_i = 16'd2;
        tick();
        idle_in();
        b4.in_valid_i = 1'b1; b4.in_data_i = mkvec(40); tick();
        b4.in_data_i = mkvec(44); tick();
        idle_in();
        tick();
        b4.abort_i = 1'b1;
        tick();
        b4.abort_i = 1'b0;
        n_vec++;
        if ((b4.west_valid_o !== '0) || (b4.west_o !== '0) || (b4.busy_o !== 1'b0) || (b4.done_o !== 1'b0)) begin
            n_err++;
            $display("FAIL abort_flush got=%b/%h/%b/%b exp=0/0/0/0", b4.west_valid_o, b4.west_o, b4.busy_o, b4.done_o);
        end
        run_idle(6);
        check_done("abort", 0, -1);
        b4.start_i = 1'b1; b4.len_i = 16'd1;
        tick(); s = cyc;
        idle_in();
        b4.in_valid_i = 1'b1; b4.in_data_i = mkvec(60); tick();
        idle_in();
        run_idle(6);
        check_done("after_abort", 1, s + 4);
    endtask

    task automatic test_async_reset();
        int s;
        idle_in();
        b4.start_i = 1'b1; b4.len_i = 16'd4;
        tick();
        idle_in();
        b4.in_valid_i = 1'b1; b4.in_data_i = mkvec(70); tick();
        b4.in_data_i = mkvec(74); tick();
        rstn = 1'b0;
        #2;
        n_vec++;
        if ((b4.west_valid_o !== '0) || (b4.west_o !== '0) || (b4.busy_o !== 1'b0) ||
            (b4.in_ready_o !== 1'b0) || (b4.done_o !== 1'b0)) begin
            n_err++;
            $display("FAIL async_reset got=%b/%h/%b/%b/%b exp=all zero", b4.west_valid_o, b4.west_o,
                     b4.busy_o, b4.in_ready_o, b4.done_o);
        end
        model_clear();
        idle_in();
        tick();
        rstn = 1'b1;
        b4.start_i = 1'b1; b4.len_i = 16'd2;
        tick(); s = cyc;
        idle_in();
        b4.in_valid_i = 1'b1; b4.in_data_i = mkvec(80); tick();
        b4.in_data_i = mkvec(84); tick();
        idle_in();
        run_idle(8);
        check_done("after_reset", 1, s + 5);
    endtask

    task automatic test_rows1();
        idle_in();
        b1.start_i = 1'b1; b1.len_i = 16'd2;
        tick();
        b1.start_i = 1'b0; b1.len_i = '0;
        n_vec++;
        if ((b1.busy_o !== 1'b1) || (b1.in_ready_o !== 1'b1) || (b1.west_valid_o !== 1'b0)) begin
            n_err++; $display("FAIL rows1_start got=%b%b%b exp=110", b1.busy_o, b1.in_ready_o, b1.west_valid_o);
        end
        b1.in_valid_i = 1'b1; b1.in_data_i = 8'h5A;
        tick();
        n_vec++;
        if ((b1.west_o !== 8'h5A) || (b1.west_valid_o !== 1'b1) || (b1.done_o !== 1'b0) || (b1.busy_o !== 1'b1)) begin
            n_err++; $display("FAIL rows1_first got=%h/%b/%b/%b exp=5a/1/0/1", b1.west_o, b1.west_valid_o, b1.done_o, b1.busy_o);
        end
        b1.in_data_i = 8'hA5;
        tick();
        n_vec++;
        if ((b1.west_o !== 8'hA5) || (b1.west_valid_o !== 1'b1) || (b1.done_o !== 1'b1) ||
            (b1.busy_o !== 1'b0) || (b1.in_ready_o !== 1'b0)) begin
            n_err++; $display("FAIL rows1_last got=%h/%b/%b/%b/%b exp=a5/1/1/0/0", b1.west_o, b1.west_valid_o,
                              b1.done_o, b1.busy_o, b1.in_ready_o);
        end
        b1.in_valid_i = 1'b0; b1.in_data_i = '0;
        tick();
        n_vec++;
        if ((b1.west_o !== 8'h00) || (b1.west_valid_o !== 1'b0) || (b1.done_o !== 1'b0)) begin
            n_err++; $display("FAIL rows1_after got=%h/%b/%b exp=00/0/0", b1.west_o, b1.west_valid_o, b1.done_o);
        end
        obs_n_done = 0;
        obs_done_at = -1;
    endtask

    task automatic test_random();
        int guard;
        for (int t = 0; t < 20; t++) begin
            idle_in();
            b4.start_i = 1'b1; b4.len_i = LW'($urandom_range(0, 6));
            tick();
            idle_in();
            guard = 0;
            while (m_active && (guard < 100)) begin
                b4.in_valid_i = ($urandom_range(0, 3) != 0);
                b4.in_data_i  = $urandom();
                b4.start_i    = ($urandom_range(0, 7) == 0);
                b4.len_i      = LW'($urandom_range(1, 9));
                b4.abort_i    = ($urandom_range(0, 39) == 0);
                tick();
                guard++;
            end
            if (guard >= 100) begin
                n_vec++; n_err++;
                $display("FAIL random_timeout tile=%0d busy=%b", t, b4.busy_o);
            end
            idle_in();
            run_idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic_skew();
        test_stall();
        test_zero_len_and_busy_start();
        test_abort();
        test_async_reset();
        test_rows1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/west_skew_feeder.md
# west_skew_feeder

Upstream feeder for the systolic array's west edge. It accepts one column vector (ROWS signed elements) per cycle through a valid/ready handshake and drives each row's west input through a per-row delay line. Row r is delayed by r cycles, producing the diagonal skew the processing-element grid needs. It pads skew slots with zeros, frames each tile by a programmed vector count, and signals completion once the last element has left the bottom row.

## Interface
- WIDTH, 8, signed element width; matches PE data width
- ROWS, 4, number of array rows fed (>=1)
- LEN_W, 16, width of tile length field

- clk_i  input  1  clock
- rstn_i  input  1  reset, asynchronous, active-low
- start_i  input  1  begin a tile; sampled only in IDLE
- len_i  input  LEN_W  vectors in tile (K); sampled with start_i
- abort_i  input  1  synchronous abort; flush and return to IDLE
- in_valid_i  input  1  in_data_i valid
- in_data_i  input  ROWS*WIDTH  column vector; row r at bits [r*WIDTH +: WIDTH]
- in_ready_o  output  1  feeder accepts a vector this cycle
- west_o  output  ROWS*WIDTH  skewed data to array west inputs, same packing
- west_valid_o  output  ROWS  per-row valid of west_o
- busy_o  output  1  high in STREAM or DRAIN
- done_o  output  1  one-cycle pulse when tile fully emitted

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - in_ready_o=0.
  - start_i=1 with len_i!=0 → STREAM; remaining counter loaded with len_i.
  - start_i with len_i==0 is ignored: no state change, no done_o.
- STREAM:
  - in_ready_o=1 combinationally.
  - Handshake = in_valid_i & in_ready_o; each handshake decrements the remaining counter.
  - Handshake on the final vector (counter==1): go to DRAIN with drain counter = ROWS-1. If ROWS==1, go straight to IDLE and pulse done_o.
- DRAIN:
  - in_ready_o=0.
  - Drain counter decrements every cycle.
  - On the edge where it goes 1→0: go to IDLE and pulse done_o.
- Delay lines:
  - Every row shifts every cycle in all states, so stalls cannot reorder data.
  - A cycle with no handshake injects a bubble: data 0, valid 0.
  - Row r has r+1 register stages, data plus valid bit.
- Bubble and pad slots drive west_o row = 0, so PEs accumulate nothing from skew padding.
- start_i in STREAM/DRAIN is ignored.
- abort_i (any state, priority over start_i and handshake):
  - Clears all delay-line stages and counters.
  - Next state IDLE; done_o is not pulsed.
  - in_ready_o is 0 in the abort cycle.
- Data passes unmodified; no arithmetic on elements. Counters are LEN_W bits and never wrap, because the FSM leaves STREAM at 1.

## Timing
- Reset values: state IDLE, all delay stages 0. So west_o=0, west_valid_o=0, in_ready_o=0, busy_o=0, done_o=0.
- Latency: a vector accepted at edge k appears on row r during the cycle after edge k+r. Row 0 latency is 1 cycle; row ROWS-1 latency is ROWS cycles.
- Tile of K vectors, all handshakes back-to-back from edge k0:
  - Last handshake at edge k0+K-1.
  - Last element appears on row ROWS-1 after edge k0+K-1+ROWS-1.
  - done_o is high in that same cycle, and busy_o falls in that cycle.
- A new start_i is accepted in the cycle done_o is high (state already IDLE).
- done_o and busy_o are registered (state-derived); in_ready_o is state-derived with no input dependence except abort_i.
- Reset mid-tile: asynchronous clear to reset values; partial tile is discarded.

## Test plan
- **Basic skew.** ROWS=4, len=3, vectors {1,2,3,4},{5,6,7,8},{9,10,11,12} back-to-back after start.
  - Row 0 shows 1,5,9 in cycles k+1..k+3; row 3 shows 4,8,12 in cycles k+4..k+6.
  - Zeros with valid=0 elsewhere.
  - done_o high exactly in cycle k+6, single pulse.
- **Stall bubble.** Same tile with in_valid_i low for 2 cycles between vectors 1 and 2.
  - Every row shows exactly two valid=0, data=0 slots between its elements.
  - done_o shifts later by 2 cycles.
- **Zero length and busy start.**
  - start with len_i=0: stays IDLE, in_ready_o=0, no done_o.
  - start pulsed mid-STREAM: counter unchanged, tile completes normally.
- **Abort.** abort_i asserted in DRAIN after len=2.
  - Next cycle: all west_valid_o=0, west_o=0, busy_o=0, no done_o.
  - A subsequent len=1 tile runs correctly.
- **Async reset.** rstn_i low mid-STREAM: outputs immediately at reset values; after release, a fresh start works.
- **Degenerate ROWS=1, len=2.** Outputs appear 1 cycle after each handshake; no DRAIN state; done_o in the cycle the second element appears.
